// File: rtl/craft_pkg.sv
// Shared CRAFT constants: cell width, S-box table and FSM encoding.
// The S-box is an involution, so one table serves both directions.
package craft_pkg;

    localparam int NIBBLE_W = 4;
    localparam int STATE_W  = 64;

    // Nibble i of the table holds S(i).
    localparam logic [63:0] SBOX_TBL = 64'h6420_5198_7FBE_3DAC;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fsm_e;

    function automatic logic [NIBBLE_W-1:0] sbox(input logic [NIBBLE_W-1:0] x);
        return SBOX_TBL[{x, 2'b00} +: NIBBLE_W];
    endfunction

endpackage

// File: rtl/craft_sbox.sv
// Single 4-bit CRAFT S-box cell (forward and inverse are identical).
module craft_sbox
    import craft_pkg::*;
(
    input  logic [NIBBLE_W-1:0] nib_i,
    output logic [NIBBLE_W-1:0] nib_o
);

    always_comb nib_o = sbox(nib_i);

endmodule

// File: rtl/craft_inv_sub_cells_serial.sv
// Nibble-serial inverse SubCells layer for CRAFT decryption.
// Optional involution self-check enabled by CRAFT_INV_SBOX_CHECK_EN.
module craft_inv_sub_cells_serial
    import craft_pkg::*;
#(
    parameter int NIBBLES = 16,
    parameter int NPAR    = 1
) (
    input  logic                          CLK,
    input  logic                          RST_N,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [NIBBLE_W*NIBBLES-1:0]   in_state,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [NIBBLE_W*NIBBLES-1:0]   out_state,
    output logic                          busy,
    output logic                          fault
);

    localparam int W     = NIBBLE_W * NIBBLES;
    localparam int SW    = NIBBLE_W * NPAR;
    localparam int STEPS = NIBBLES / NPAR;
    localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(STEPS - 1);

    fsm_e             fsm_q, fsm_d;
    logic [W-1:0]     st_q, st_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SW-1:0]    cur, sub;
    logic             accept;

    assign accept    = in_valid && in_ready;
    assign in_ready  = (fsm_q == IDLE);
    assign out_valid = (fsm_q == DONE);
    assign busy      = (fsm_q != IDLE);
    assign out_state = out_valid ? st_q : '0;

    always_comb begin
        cur = '0;
        for (int s = 0; s < STEPS; s++) begin
            if (cnt_q == CNT_W'(s)) cur = st_q[s*SW +: SW];
        end
    end

    for (genvar p = 0; p < NPAR; p++) begin : g_inv
        craft_sbox u_inv (
            .nib_i (cur[p*NIBBLE_W +: NIBBLE_W]),
            .nib_o (sub[p*NIBBLE_W +: NIBBLE_W])
        );
    end

    always_comb begin
        fsm_d = fsm_q;
        cnt_d = cnt_q;
        st_d  = st_q;
        unique case (fsm_q)
            IDLE: begin
                if (accept) begin
                    fsm_d = RUN;
                    cnt_d = '0;
                    st_d  = in_state;
                end
            end
            RUN: begin
                for (int s = 0; s < STEPS; s++) begin
                    if (cnt_q == CNT_W'(s)) st_d[s*SW +: SW] = sub;
                end
                // cnt parks on the last step instead of wrapping
                if (cnt_q == LAST) fsm_d = DONE;
                else               cnt_d = cnt_q + 1'b1;
            end
            DONE: begin
                if (out_ready) fsm_d = IDLE;
            end
            default: fsm_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            fsm_q <= IDLE;
            cnt_q <= '0;
            st_q  <= '0;
        end else begin
            fsm_q <= fsm_d;
            cnt_q <= cnt_d;
            st_q  <= st_d;
        end
    end

`ifdef CRAFT_INV_SBOX_CHECK_EN
    logic [SW-1:0] back;
    logic          fault_q;

    for (genvar p = 0; p < NPAR; p++) begin : g_chk
        craft_sbox u_fwd (
            .nib_i (sub[p*NIBBLE_W +: NIBBLE_W]),
            .nib_o (back[p*NIBBLE_W +: NIBBLE_W])
        );
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)                            fault_q <= 1'b0;
        else if (accept)                       fault_q <= 1'b0;
        else if (fsm_q == RUN && back != cur)  fault_q <= 1'b1;
    end

    assign fault = fault_q;
`else
    assign fault = 1'b0;
`endif

endmodule

// File: tb/tb_craft_inv_sub_cells_serial.sv
// Scoreboard bench for craft_inv_sub_cells_serial (NPAR=1 and NPAR=4).
module tb_craft_inv_sub_cells_serial;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic        RST_N;
    logic        in_valid, in_ready, out_valid, out_ready, busy, fault;
    logic [63:0] in_state, out_state;
    logic        in_valid4, in_ready4, out_valid4, out_ready4, busy4, fault4;
    logic [63:0] in_state4, out_state4;

    int          n_chk = 0;
    int          n_pass = 0;
    logic [63:0] sb[$];
    logic [63:0] sb4[$];

    craft_inv_sub_cells_serial #(.NIBBLES(16), .NPAR(1)) u_dut (
        .CLK(CLK), .RST_N(RST_N),
        .in_valid(in_valid), .in_ready(in_ready), .in_state(in_state),
        .out_valid(out_valid), .out_ready(out_ready), .out_state(out_state),
        .busy(busy), .fault(fault)
    );

    craft_inv_sub_cells_serial #(.NIBBLES(16), .NPAR(4)) u_dut4 (
        .CLK(CLK), .RST_N(RST_N),
        .in_valid(in_valid4), .in_ready(in_ready4), .in_state(in_state4),
        .out_valid(out_valid4), .out_ready(out_ready4), .out_state(out_state4),
        .busy(busy4), .fault(fault4)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    function automatic logic [3:0] m_sbox(input logic [3:0] x);
        case (x)
            4'h0: return 4'hC; 4'h1: return 4'hA; 4'h2: return 4'hD; 4'h3: return 4'h3;
            4'h4: return 4'hE; 4'h5: return 4'hB; 4'h6: return 4'hF; 4'h7: return 4'h7;
            4'h8: return 4'h8; 4'h9: return 4'h9; 4'hA: return 4'h1; 4'hB: return 4'h5;
            4'hC: return 4'h0; 4'hD: return 4'h2; 4'hE: return 4'h4; default: return 4'h6;
        endcase
    endfunction

    function automatic logic [63:0] m_sub(input logic [63:0] x);
        logic [63:0] r;
        for (int i = 0; i < 16; i++) r[4*i +: 4] = m_sbox(x[4*i +: 4]);
        return r;
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic accept(input logic [63:0] st);
        chk("idle_ready", {63'd0, in_ready}, 64'd1);
        in_valid = 1'b1;
        in_state = st;
        tick();
        in_valid = 1'b0;
        in_state = {$urandom, $urandom};
        sb.push_back(m_sub(st));
        chk("run_busy", {63'd0, busy}, 64'd1);
        chk("run_ready", {63'd0, in_ready}, 64'd0);
        chk("run_state0", out_state, 64'd0);
    endtask

    task automatic wait_done(input int exp_lat);
        int lat = 0;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
        chk("latency", 64'(lat), 64'(exp_lat));
    endtask

    task automatic drain(input int hold);
        logic [63:0] held;
        held = out_state;
        repeat (hold) begin
            chk("hold_valid", {63'd0, out_valid}, 64'd1);
            chk("hold_ready", {63'd0, in_ready}, 64'd0);
            chk("hold_state", out_state, held);
            tick();
        end
        out_ready = 1'b1;
        chk("done_valid", {63'd0, out_valid}, 64'd1);
        chk("handoff_ready", {63'd0, in_ready}, 64'd0);
        chk("fault", {63'd0, fault}, 64'd0);
        if (sb.size() == 0) chk("sb_empty", 64'd1, 64'd0);
        else                chk("result", out_state, sb.pop_front());
        tick();
        out_ready = 1'b0;
        chk("post_ready", {63'd0, in_ready}, 64'd1);
        chk("post_valid", {63'd0, out_valid}, 64'd0);
        chk("post_state", out_state, 64'd0);
        chk("post_busy", {63'd0, busy}, 64'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ready"}, {63'd0, in_ready}, 64'd1);
        chk({tag, "_valid"}, {63'd0, out_valid}, 64'd0);
        chk({tag, "_state"}, out_state, 64'd0);
        chk({tag, "_busy"}, {63'd0, busy}, 64'd0);
        chk({tag, "_fault"}, {63'd0, fault}, 64'd0);
    endtask

    initial begin
        RST_N = 1'b1;
        in_valid = 1'b0; in_state = '0; out_ready = 1'b0;
        in_valid4 = 1'b0; in_state4 = '0; out_ready4 = 1'b0;
        #2 RST_N = 1'b0;
        #1 check_reset_outputs("rst");
        chk("rst4_ready", {63'd0, in_ready4}, 64'd1);
        repeat (2) @(posedge CLK);
        #1 RST_N = 1'b1;
        tick();

        accept(64'h0123456789ABCDEF);
        wait_done(16);
        chk("t1_const", out_state, 64'hCAD3EBF789150246);
        drain(0);

        accept(64'hCAD3EBF789150246);
        wait_done(16);
        chk("t2_roundtrip", out_state, 64'h0123456789ABCDEF);
        drain(0);

        accept(64'h0);
        wait_done(16);
        chk("t3_const", out_state, 64'hCCCCCCCCCCCCCCCC);
        drain(5);

        accept(64'h1122334455667788);
        repeat (7) tick();
        RST_N = 1'b0;
        #1 check_reset_outputs("rst_run");
        sb.delete();
        tick();
        RST_N = 1'b1;
        tick();
        accept(64'hDEADBEEF01234567);
        wait_done(16);
        drain(2);

        accept(64'h0F1E2D3C4B5A6978);
        wait_done(16);
        RST_N = 1'b0;
        #1 check_reset_outputs("rst_done");
        sb.delete();
        tick();
        RST_N = 1'b1;
        tick();

        repeat (4) begin
            accept({$urandom, $urandom});
            wait_done(16);
            drain(int'($urandom_range(0, 3)));
        end

        chk("t5_idle_ready", {63'd0, in_ready4}, 64'd1);
        in_valid4 = 1'b1;
        in_state4 = 64'hFEDCBA9876543210;
        tick();
        sb4.push_back(m_sub(64'hFEDCBA9876543210));
        in_state4 = 64'h5555AAAA5555AAAA;
        begin
            int lat = 0;
            while (!out_valid4 && lat < 20) begin
                chk("t5_run_ready", {63'd0, in_ready4}, 64'd0);
                tick();
                lat++;
            end
            chk("t5_latency", 64'(lat), 64'd4);
        end
        in_valid4 = 1'b0;
        chk("t5_valid", {63'd0, out_valid4}, 64'd1);
        if (sb4.size() == 0) chk("t5_sb_empty", 64'd1, 64'd0);
        else                 chk("t5_result", out_state4, sb4.pop_front());
        chk("t5_fault", {63'd0, fault4}, 64'd0);
        out_ready4 = 1'b1;
        tick();
        out_ready4 = 1'b0;
        chk("t5_post_ready", {63'd0, in_ready4}, 64'd1);
        chk("t5_post_valid", {63'd0, out_valid4}, 64'd0);
        tick();
        chk("t5_no_reaccept", {63'd0, busy4}, 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
